writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 135 +++++++++++++
 tb/tb_writeback_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// writeback_stage : arbitrates ALU/load results into a FIFO that drains into
// the register-file write port. Optional WB_FWD_EN adds forwarding. Rev 1.0
// ----------------------------------------------------------------------------
module writeback_stage #(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [n-1:0]               alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_rd,
  input  logic [n-1:0]               mem_data,
  input  logic [2:0]                 mem_funct3,
  input  logic [1:0]                 mem_addr_lo,
  input  logic                       wb_stall,
`ifdef WB_FWD_EN
  input  logic [4:0]                 fwd_raddr,
  output logic                       fwd_hit,
  output logic [n-1:0]               fwd_data,
`endif
  output logic                       regw,
  output logic [5:0]                 waddr,
  output logic [n-1:0]               wdata,
  output logic [$clog2(DEPTH):0]     wb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    q_rd   [DEPTH];
  logic [n-1:0]  q_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic          has_room, push_mem, push_alu, push, pop;
  logic [4:0]    push_rd;
  logic [n-1:0]  push_data, ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign has_room  = !reset && (wb_count < FULL);
  assign mem_ready = has_room;
  assign alu_ready = has_room && !mem_valid;
  assign push_mem  = mem_valid && mem_ready;
  assign push_alu  = alu_valid && alu_ready;
  assign push      = push_mem || push_alu;
  assign pop       = (wb_count != '0) && !wb_stall;

  // Byte/half lanes follow little-endian addressing within the word.
  always_comb begin
    ld_byte = mem_data[7:0];
    case (mem_addr_lo)
      2'd0:    ld_byte = mem_data[7:0];
      2'd1:    ld_byte = mem_data[15:8];
      2'd2:    ld_byte = mem_data[23:16];
      default: ld_byte = mem_data[31:24];
    endcase
    ld_half = mem_addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
    case (mem_funct3)
      3'b000:  ld_data = {{(n-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(n-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(n-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(n-16){1'b0}}, ld_half};
      default: ld_data = mem_data;
    endcase
  end

  assign push_rd   = push_mem ? mem_rd  : alu_rd;
  assign push_data = push_mem ? ld_data : alu_data;

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      q_rd[wr_ptr]   <= push_rd;
      q_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_count <= '0;
      regw     <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      regw <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        regw   <= (q_rd[rd_ptr] != 5'd0);
        waddr  <= {1'b0, q_rd[rd_ptr]};
        wdata  <= q_data[rd_ptr];
      end
      case ({push, pop})
        2'b10:   wb_count <= wb_count + 1'b1;
        2'b01:   wb_count <= wb_count - 1'b1;
        default: wb_count <= wb_count;
      endcase
    end
  end

`ifdef WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest match wins; output register is oldest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (fwd_raddr != 5'd0) begin
      if (regw && (waddr[4:0] == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr + PW'(i);
        if ((CW'(i) < wb_count) && (q_rd[fwd_idx] == fwd_raddr)) begin
          fwd_hit  = 1'b1;
          fwd_data = q_data[fwd_idx];
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_writeback_stage : directed self-checking bench for writeback_stage. Rev 1.0
// ----------------------------------------------------------------------------
module tb_writeback_stage;
  localparam int N = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]    alu_rd, mem_rd;
  logic [N-1:0]  alu_data, mem_data;
  logic [2:0]    mem_funct3;
  logic [1:0]    mem_addr_lo;
  logic          wb_stall, regw;
  logic [5:0]    waddr;
  logic [N-1:0]  wdata;
  logic [2:0]    wb_count;
`ifdef WB_FWD_EN
  logic [4:0]    fwd_raddr;
  logic          fwd_hit;
  logic [N-1:0]  fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  writeback_stage #(.n(N), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .wb_stall(wb_stall),
`ifdef WB_FWD_EN
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .regw(regw), .waddr(waddr), .wdata(wdata), .wb_count(wb_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic r, input logic [5:0] a, input logic [31:0] d);
    check({tag, ".regw"},  64'(regw),  64'(r));
    check({tag, ".waddr"}, 64'(waddr), 64'(a));
    check({tag, ".wdata"}, 64'(wdata), 64'(d));
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0;
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
    mem_funct3 = '0; mem_addr_lo = '0;
`ifdef WB_FWD_EN
    fwd_raddr = '0;
`endif
    mem_valid = 1'b1;
    step(); step();
    check("rst.mem_ready", 64'(mem_ready), 64'd0);
    check("rst.alu_ready", 64'(alu_ready), 64'd0);
    check("rst.count", 64'(wb_count), 64'd0);
    check_out("rst", 1'b0, 6'd0, 32'd0);
    mem_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("idle.mem_ready", 64'(mem_ready), 64'd1);

    // Scenario 1: single ALU write, one-edge latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1 check("s1.alu_ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    check("s1.count_push", 64'(wb_count), 64'd1);
    check("s1.regw_push", 64'(regw), 64'd0);
    step();
    check_out("s1.pop", 1'b1, 6'd5, 32'h1234);
    check("s1.count_pop", 64'(wb_count), 64'd0);
    step();
    check_out("s1.after", 1'b0, 6'd5, 32'h1234);

    // Scenario 2: load formatting LB / LHU
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h80FF0000;
    mem_funct3 = 3'b000; mem_addr_lo = 2'd3;
    step();
    mem_rd = 5'd4; mem_funct3 = 3'b101; mem_addr_lo = 2'd2;
    step();
    mem_valid = 1'b0;
    check_out("s2.lb", 1'b1, 6'd3, 32'hFFFFFF80);
    check("s2.count_pushpop", 64'(wb_count), 64'd1);
    step();
    check_out("s2.lhu", 1'b1, 6'd4, 32'h000080FF);
    step();
    check("s2.idle_regw", 64'(regw), 64'd0);

    // Scenario 3: mem has priority over alu
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'hCAFE; mem_funct3 = 3'b010; mem_addr_lo = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hBEEF;
    #1;
    check("s3.alu_ready_blk", 64'(alu_ready), 64'd0);
    check("s3.mem_ready", 64'(mem_ready), 64'd1);
    step();
    mem_valid = 1'b0;
    #1 check("s3.alu_ready_free", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    check_out("s3.mem_first", 1'b1, 6'd6, 32'hCAFE);
    step();
    check_out("s3.alu_second", 1'b1, 6'd7, 32'hBEEF);
    step();
    check("s3.count_empty", 64'(wb_count), 64'd0);

    // Scenario 4: fill under stall (pointers wrap), then drain in order
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(i);
      step();
    end
    alu_rd = 5'd20; alu_data = 32'hBAD;
    #1;
    check("s4.count_full", 64'(wb_count), 64'd4);
    check("s4.alu_ready", 64'(alu_ready), 64'd0);
    check("s4.mem_ready", 64'(mem_ready), 64'd0);
    check("s4.regw_stall", 64'(regw), 64'd0);
    step();
    alu_valid = 1'b0;
    check("s4.count_no_overflow", 64'(wb_count), 64'd4);
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out($sformatf("s4.drain%0d", i), 1'b1, 6'(10 + i), 32'h100 + 32'(i));
    end
    step();
    check("s4.count_empty", 64'(wb_count), 64'd0);
    check("s4.regw_idle", 64'(regw), 64'd0);

    // Scenario 5: rd=0 suppresses write; reset flushes a partly full queue
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    step();
    alu_valid = 1'b0;
    step();
    check_out("s5.rd0", 1'b0, 6'd0, 32'hDEAD);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'h50 + 32'(i);
      step();
    end
    check("s5.count3", 64'(wb_count), 64'd3);
    reset = 1'b1;
    #1 check("s5.rst_alu_ready", 64'(alu_ready), 64'd0);
    step();
    reset = 1'b0; alu_valid = 1'b0; wb_stall = 1'b0;
    check("s5.rst_count", 64'(wb_count), 64'd0);
    check_out("s5.rst", 1'b0, 6'd0, 32'd0);
    step();
    check("s5.post_rst_regw", 64'(regw), 64'd0);
    check("s5.post_rst_count", 64'(wb_count), 64'd0);

`ifdef WB_FWD_EN
    // Scenario 6: youngest queued match is forwarded
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
    step();
    alu_data = 32'h2;
    step();
    alu_valid = 1'b0;
    fwd_raddr = 5'd7;
    #1;
    check("s6.hit", 64'(fwd_hit), 64'd1);
    check("s6.data", 64'(fwd_data), 64'h2);
    fwd_raddr = 5'd0;
    #1 check("s6.r0_hit", 64'(fwd_hit), 64'd0);
    wb_stall = 1'b0;
    step(); step(); step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
